// File: rtl/alu_csr_q_pkg.sv
// rtl/alu_csr_q_pkg.sv - issue-bus command encoding shared by the ALUs
package alu_csr_q_pkg;

   typedef enum logic [3:0] {
      ALU_NOP    = 4'h0,
      ALU_ADD    = 4'h1,
      ALU_SUB    = 4'h2,
      ALU_AND    = 4'h3,
      ALU_OR     = 4'h4,
      ALU_XOR    = 4'h5,
      ALU_SLL    = 4'h6,
      ALU_SRL    = 4'h7,
      ALU_CSRRW  = 4'h8,
      ALU_CSRRS  = 4'h9,
      ALU_CSRRC  = 4'hA,
      ALU_CSRRWI = 4'hC,
      ALU_CSRRSI = 4'hD,
      ALU_CSRRCI = 4'hE
   } alu_commands_t;

endpackage

// File: rtl/alu_csr_q.sv
// rtl/alu_csr_q.sv - queued CSR read-modify-write unit (optional ALU_CSR_RO_CHECK_EN)
module alu_csr_q
   import alu_csr_q_pkg::*;
#(
   parameter int XLEN       = 32,
   parameter int CSR_ADDR_W = 12,
   parameter int REG_ADDR_W = 5,
   parameter int QDEPTH     = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [XLEN-1:0]       arg0,
   input  logic [XLEN-1:0]       imm,
   input  alu_commands_t         cmd,
   input  logic [REG_ADDR_W-1:0] i_rs1,
   input  logic [REG_ADDR_W-1:0] i_rd,
   output logic                  busy,
   output logic                  i_error,
   output logic [XLEN-1:0]       res,
   output logic [REG_ADDR_W-1:0] o_rd,
   output logic                  valid,
   output logic                  o_error,
   output logic                  req,
   input  logic                  clear,
   output logic [CSR_ADDR_W-1:0] csr_ra,
   output logic                  csr_re,
   input  logic [XLEN-1:0]       csr_rd,
   output logic [CSR_ADDR_W-1:0] csr_wa,
   output logic                  csr_we,
   output logic [XLEN-1:0]       csr_wd,
   input  logic                  csr_err
);

   localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
   localparam int CW = $clog2(QDEPTH + 1);

   typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_RESP} state_t;
   typedef enum logic [1:0] {OP_RW, OP_RS, OP_RC} op_t;

   // decoded issue-bus request
   logic                  is_csr, in_imm, in_wsupp, in_rsupp, push, pop;
   op_t                   in_op;
   logic [4:0]            zimm;
   logic [XLEN-1:0]       in_src;

   // command FIFO
   op_t                   op_mem    [QDEPTH];
   logic [CSR_ADDR_W-1:0] addr_mem  [QDEPTH];
   logic [XLEN-1:0]       src_mem   [QDEPTH];
   logic [REG_ADDR_W-1:0] rd_mem    [QDEPTH];
   logic                  wsupp_mem [QDEPTH];
   logic                  rsupp_mem [QDEPTH];
   logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]         count_q;

   // working registers of the command in flight
   state_t                state_q, state_d;
   op_t                   op_q;
   logic [CSR_ADDR_W-1:0] addr_q;
   logic [XLEN-1:0]       src_q;
   logic [REG_ADDR_W-1:0] rd_q;
   logic                  wsupp_q, rsupp_q;
   logic [XLEN-1:0]       readback_q, readback_d;
   logic                  err_q, err_d;
   logic                  ro_hit;
   logic                  unused_imm;

   assign unused_imm = ^imm[XLEN-1:CSR_ADDR_W+5];

`ifdef ALU_CSR_RO_CHECK_EN
   // top address bits 2'b11 mark the read-only CSR space
   assign ro_hit = (addr_q[CSR_ADDR_W-1 -: 2] == 2'b11) && !wsupp_q;
`else
   assign ro_hit = 1'b0;
`endif

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(QDEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // decode the offered command and its suppression flags
   always_comb begin
      is_csr = 1'b1;
      in_op  = OP_RW;
      in_imm = 1'b0;
      case (cmd)
         ALU_CSRRW:  in_op = OP_RW;
         ALU_CSRRS:  in_op = OP_RS;
         ALU_CSRRC:  in_op = OP_RC;
         ALU_CSRRWI: begin in_op = OP_RW; in_imm = 1'b1; end
         ALU_CSRRSI: begin in_op = OP_RS; in_imm = 1'b1; end
         ALU_CSRRCI: begin in_op = OP_RC; in_imm = 1'b1; end
         default:    is_csr = 1'b0;
      endcase
   end

   assign zimm     = imm[CSR_ADDR_W+4:CSR_ADDR_W];
   assign in_src   = in_imm ? {{(XLEN-5){1'b0}}, zimm} : arg0;
   assign in_wsupp = (in_op != OP_RW) && (in_imm ? (zimm == 5'd0) : (i_rs1 == '0));
   assign in_rsupp = (in_op == OP_RW) && (i_rd == '0);
   assign i_error  = !is_csr;
   // busy comes from the registered count: a same-cycle pop never frees a slot early
   assign busy     = (count_q == CW'(QDEPTH));
   assign push     = is_csr && !busy;
   assign req      = 1'b0;

   // FIFO storage needs no reset; the count qualifies it
   always_ff @(posedge clk) begin
      if (push) begin
         op_mem[wr_ptr_q]    <= in_op;
         addr_mem[wr_ptr_q]  <= imm[CSR_ADDR_W-1:0];
         src_mem[wr_ptr_q]   <= in_src;
         rd_mem[wr_ptr_q]    <= i_rd;
         wsupp_mem[wr_ptr_q] <= in_wsupp;
         rsupp_mem[wr_ptr_q] <= in_rsupp;
      end
   end

   // FIFO pointers and occupancy
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
         if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
         case ({push, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   // sequencer next state and CSR-port / result outputs
   always_comb begin
      state_d    = state_q;
      pop        = 1'b0;
      readback_d = readback_q;
      err_d      = err_q;
      csr_ra     = '0;
      csr_re     = 1'b0;
      csr_wa     = '0;
      csr_we     = 1'b0;
      csr_wd     = '0;
      valid      = 1'b0;
      res        = '0;
      o_rd       = '0;
      o_error    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (count_q != '0) begin
               pop     = 1'b1;
               state_d = S_READ;
            end
         end
         S_READ: begin
            csr_ra     = addr_q;
            csr_re     = !rsupp_q;
            readback_d = rsupp_q ? '0 : csr_rd;
            err_d      = csr_err && !rsupp_q;
            state_d    = S_WRITE;
         end
         S_WRITE: begin
            csr_wa = addr_q;
            csr_we = !wsupp_q && !ro_hit;
            case (op_q)
               OP_RS:   csr_wd = readback_q | src_q;
               OP_RC:   csr_wd = readback_q & ~src_q;
               default: csr_wd = src_q;
            endcase
            err_d   = err_q || (csr_err && csr_we) || ro_hit;
            state_d = S_RESP;
         end
         S_RESP: begin
            valid   = 1'b1;
            res     = readback_q;
            o_rd    = rd_q;
            o_error = err_q;
            if (clear) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // sequencer state and working registers; popping loads the FIFO head
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         op_q       <= OP_RW;
         addr_q     <= '0;
         src_q      <= '0;
         rd_q       <= '0;
         wsupp_q    <= 1'b0;
         rsupp_q    <= 1'b0;
         readback_q <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         readback_q <= readback_d;
         err_q      <= err_d;
         if (pop) begin
            op_q    <= op_mem[rd_ptr_q];
            addr_q  <= addr_mem[rd_ptr_q];
            src_q   <= src_mem[rd_ptr_q];
            rd_q    <= rd_mem[rd_ptr_q];
            wsupp_q <= wsupp_mem[rd_ptr_q];
            rsupp_q <= rsupp_mem[rd_ptr_q];
         end
      end
   end

endmodule

// File: tb/tb_alu_csr_q.sv
// tb/tb_alu_csr_q.sv - randomized bench with ISA-level CSR reference model
module tb_alu_csr_q;
   import alu_csr_q_pkg::*;

   localparam logic [11:0] ERR_R = 12'h7F0;
   localparam logic [11:0] ERR_W = 12'h7F1;
`ifdef ALU_CSR_RO_CHECK_EN
   localparam bit RO_EN = 1'b1;
`else
   localparam bit RO_EN = 1'b0;
`endif

   logic          clk, rst_n;
   logic [31:0]   arg0, imm;
   alu_commands_t cmd;
   logic [4:0]    i_rs1, i_rd, o_rd;
   logic          busy, i_error, valid, o_error, req, clear;
   logic [31:0]   res, csr_rd, csr_wd;
   logic [11:0]   csr_ra, csr_wa;
   logic          csr_re, csr_we, csr_err;

   alu_csr_q dut (
      .clk(clk), .rst_n(rst_n), .arg0(arg0), .imm(imm), .cmd(cmd),
      .i_rs1(i_rs1), .i_rd(i_rd), .busy(busy), .i_error(i_error),
      .res(res), .o_rd(o_rd), .valid(valid), .o_error(o_error), .req(req),
      .clear(clear), .csr_ra(csr_ra), .csr_re(csr_re), .csr_rd(csr_rd),
      .csr_wa(csr_wa), .csr_we(csr_we), .csr_wd(csr_wd), .csr_err(csr_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // CSR file seen by the DUT, with two fault addresses
   logic [31:0] csr_mem [4096];
   assign csr_rd  = csr_re ? csr_mem[csr_ra] : 32'h0;
   assign csr_err = (csr_re && csr_ra == ERR_R) || (csr_we && csr_wa == ERR_W);
   always @(posedge clk) if (csr_we) csr_mem[csr_wa] <= csr_wd;

   // reference model state
   typedef struct { logic [31:0] res; logic [4:0] rd; logic err; } res_t;
   typedef struct { logic [11:0] a; logic [31:0] d; } wr_t;
   logic [31:0] ref_mem [4096];
   res_t exp_res [$];
   wr_t  exp_wr  [$];
   int   n_tests, n_fail, re_cnt, we_cnt, exp_re, exp_we;
   bit   hold_clear, seen;
   int   hold;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic void decode(input alu_commands_t c, output bit ok, output int kind, output bit immf);
      ok = 1'b1; kind = 0; immf = 1'b0;
      case (c)
         ALU_CSRRW:  kind = 0;
         ALU_CSRRS:  kind = 1;
         ALU_CSRRC:  kind = 2;
         ALU_CSRRWI: begin kind = 0; immf = 1'b1; end
         ALU_CSRRSI: begin kind = 1; immf = 1'b1; end
         ALU_CSRRCI: begin kind = 2; immf = 1'b1; end
         default:    ok = 1'b0;
      endcase
   endfunction

   // ISA semantics of one accepted command, applied in program order
   function automatic void model_push(input int kind, input bit immf, input logic [11:0] a,
                                      input logic [31:0] a0, input logic [4:0] z,
                                      input logic [4:0] rs1, input logic [4:0] rd);
      logic [31:0] src, rb, nv;
      bit wsupp, rsupp, err;
      res_t r;
      wr_t  w;
      src   = immf ? {27'd0, z} : a0;
      wsupp = (kind != 0) && (immf ? (z == 0) : (rs1 == 0));
      rsupp = (kind == 0) && (rd == 0);
      rb    = rsupp ? 32'h0 : ref_mem[a];
      err   = (a == ERR_R) && !rsupp;
      if (!rsupp) exp_re++;
      if (kind == 0)      nv = src;
      else if (kind == 1) nv = rb | src;
      else                nv = rb & ~src;
      if (!wsupp) begin
         if (RO_EN && a[11:10] == 2'b11) err = 1'b1;
         else begin
            w.a = a; w.d = nv;
            exp_wr.push_back(w);
            ref_mem[a] = nv;
            exp_we++;
            if (a == ERR_W) err = 1'b1;
         end
      end
      r.res = rb; r.rd = rd; r.err = err;
      exp_res.push_back(r);
   endfunction

   // offer one command for a cycle; called at a falling edge, returns at the next one
   task automatic offer(input alu_commands_t c, input logic [11:0] a, input logic [31:0] a0,
                        input logic [4:0] z, input logic [4:0] rs1, input logic [4:0] rd,
                        input bit model_en, output bit acc);
      bit ok, immf;
      int kind;
      decode(c, ok, kind, immf);
      cmd = c; imm = {15'd0, z, a}; arg0 = a0; i_rs1 = rs1; i_rd = rd;
      #1;
      check("i_error", i_error, !ok);
      acc = ok && !busy;
      if (acc && model_en) model_push(kind, immf, a, a0, z, rs1, rd);
      @(negedge clk);
      cmd = ALU_NOP;
   endtask

   task automatic drain();
      int t;
      t = 0;
      while ((exp_res.size() != 0 || valid) && t < 300) begin
         @(negedge clk);
         t++;
      end
      if (t >= 300) check("drain_timeout", 0, 1);
      repeat (2) @(negedge clk);
   endtask

   // write-port monitor
   always @(negedge clk) begin
      wr_t w;
      if (rst_n) begin
         if (csr_re) re_cnt++;
         if (csr_we) begin
            we_cnt++;
            if (exp_wr.size() == 0) check("wr_extra", 1, 0);
            else begin
               w = exp_wr.pop_front();
               check("csr_wa", csr_wa, w.a);
               check("csr_wd", csr_wd, w.d);
            end
         end
      end
   end

   // result monitor and writeback consumer with random clear delay
   always @(negedge clk) begin
      res_t r;
      if (clear) clear = 1'b0;
      else if (rst_n && valid) begin
         if (!seen) begin
            seen = 1'b1;
            if (exp_res.size() == 0) check("res_extra", 1, 0);
            else begin
               r = exp_res.pop_front();
               check("res", res, r.res);
               check("o_rd", o_rd, r.rd);
               check("o_error", o_error, r.err);
            end
            hold = $urandom_range(0, 2);
         end
         if (!hold_clear) begin
            if (hold == 0) begin clear = 1'b1; seen = 1'b0; end
            else hold--;
         end
      end
   end

   logic [11:0]   addrs [6];
   alu_commands_t ccmds [6];
   alu_commands_t ncmds [4];

   initial begin
      bit acc, acc_b, acc_c, saw;
      int w0, r0;
      addrs = '{12'h340, 12'h300, 12'h305, 12'hC00, ERR_R, ERR_W};
      ccmds = '{ALU_CSRRW, ALU_CSRRS, ALU_CSRRC, ALU_CSRRWI, ALU_CSRRSI, ALU_CSRRCI};
      ncmds = '{ALU_NOP, ALU_ADD, ALU_XOR, ALU_SLL};
      n_tests = 0; n_fail = 0; re_cnt = 0; we_cnt = 0; exp_re = 0; exp_we = 0;
      hold_clear = 1'b0; seen = 1'b0; hold = 0;
      rst_n = 1'b0; cmd = ALU_NOP; arg0 = 0; imm = 0; i_rs1 = 0; i_rd = 0; clear = 1'b0;
      for (int i = 0; i < 4096; i++) begin csr_mem[i] = 32'h0; ref_mem[i] = 32'h0; end
      csr_mem[12'h340] = 32'h1234; ref_mem[12'h340] = 32'h1234;
      csr_mem[12'h300] = 32'h8;    ref_mem[12'h300] = 32'h8;
      csr_mem[12'h305] = 32'hF;    ref_mem[12'h305] = 32'hF;
      csr_mem[12'hC00] = 32'h5555; ref_mem[12'hC00] = 32'h5555;

      repeat (3) @(negedge clk);
      check("rst_valid", valid, 0);
      check("rst_busy", busy, 0);
      check("rst_csr_re", csr_re, 0);
      check("rst_csr_we", csr_we, 0);
      check("rst_res", res, 0);
      check("rst_o_rd", o_rd, 0);
      check("rst_o_error", o_error, 0);
      check("rst_req", req, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // CSRRW with fixed latency
      offer(ALU_CSRRW, 12'h340, 32'hDEAD_BEEF, 5'd0, 5'd1, 5'd5, 1'b1, acc);
      check("lat_idle_re", csr_re, 0);
      @(negedge clk);
      check("lat_read_re", csr_re, 1);
      check("lat_read_ra", csr_ra, 32'h340);
      @(negedge clk);
      check("lat_write_we", csr_we, 1);
      check("lat_write_wd", csr_wd, 32'hDEAD_BEEF);
      @(negedge clk);
      check("lat_resp_valid", valid, 1);
      check("lat_resp_res", res, 32'h1234);
      check("lat_resp_rd", o_rd, 5);
      drain();

      // CSRRS with rs1=x0: no write
      w0 = we_cnt;
      offer(ALU_CSRRS, 12'h300, 32'hFFFF_FFFF, 5'd0, 5'd0, 5'd3, 1'b1, acc);
      drain();
      check("rs_x0_no_we", we_cnt - w0, 0);

      // CSRRCI zimm=3 on 0xF gives 0xC
      offer(ALU_CSRRCI, 12'h305, 32'h0, 5'd3, 5'd0, 5'd4, 1'b1, acc);
      drain();
      check("rci_result", csr_mem[12'h305], 32'hC);

      // CSRRW with rd=x0: no read, write still happens
      r0 = re_cnt; w0 = we_cnt;
      offer(ALU_CSRRW, 12'h340, 32'h55, 5'd0, 5'd2, 5'd0, 1'b1, acc);
      drain();
      check("rw_x0_no_re", re_cnt - r0, 0);
      check("rw_x0_we", we_cnt - w0, 1);

      // FIFO full while the FSM holds a result
      hold_clear = 1'b1;
      offer(ALU_CSRRW, 12'h340, 32'h1111, 5'd0, 5'd1, 5'd1, 1'b1, acc);
      for (int t = 0; t < 20 && !valid; t++) @(negedge clk);
      check("hold_valid", valid, 1);
      check("busy_empty", busy, 0);
      offer(ALU_CSRRS, 12'h340, 32'h0F00, 5'd0, 5'd1, 5'd2, 1'b1, acc_b);
      check("busy_one", busy, 0);
      offer(ALU_CSRRC, 12'h340, 32'h0100, 5'd0, 5'd1, 5'd3, 1'b1, acc_c);
      check("busy_full", busy, 1);
      offer(ALU_CSRRW, 12'h340, 32'h9999, 5'd0, 5'd1, 5'd4, 1'b1, acc);
      check("push2_acc", acc_b & acc_c, 1);
      check("drop_3rd", acc, 0);
      hold_clear = 1'b0;
      drain();

      // read fault reported with the result
      offer(ALU_CSRRS, ERR_R, 32'h1, 5'd0, 5'd1, 5'd6, 1'b1, acc);
      drain();

      // unknown command is not pushed
      offer(ALU_ADD, 12'h340, 32'h1, 5'd0, 5'd1, 5'd1, 1'b1, acc);
      saw = 1'b0;
      repeat (6) begin @(negedge clk); if (valid) saw = 1'b1; end
      check("unk_no_push", saw, 0);

      // write to the read-only CSR space
      w0 = we_cnt;
      offer(ALU_CSRRW, 12'hC00, 32'hAA, 5'd0, 5'd1, 5'd2, 1'b1, acc);
      drain();
      check("ro_we", we_cnt - w0, RO_EN ? 0 : 1);

      // randomized mix
      for (int i = 0; i < 200; i++) begin
         int r;
         r = $urandom_range(0, 9);
         if (r < 2)
            offer(ncmds[$urandom_range(0, 3)], addrs[$urandom_range(0, 5)], $urandom,
                  5'($urandom), 5'($urandom), 5'($urandom), 1'b1, acc);
         else if (busy && $urandom_range(0, 2) != 0)
            @(negedge clk);
         else
            offer(ccmds[$urandom_range(0, 5)], addrs[$urandom_range(0, 5)],
                  ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom,
                  ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom),
                  5'($urandom_range(0, 2)), 5'($urandom_range(0, 3)), 1'b1, acc);
      end
      drain();

      check("exp_res_empty", exp_res.size(), 0);
      check("exp_wr_empty", exp_wr.size(), 0);
      check("read_count", re_cnt, exp_re);
      check("write_count", we_cnt, exp_we);

      // reset during WRITE abandons the access
      offer(ALU_CSRRW, 12'h305, 32'h77, 5'd0, 5'd1, 5'd0, 1'b0, acc);
      @(posedge clk);
      @(posedge clk);
      #2;
      check("rst_pre_we", csr_we, 1);
      rst_n = 1'b0;
      @(negedge clk);
      check("rst_mid_we", csr_we, 0);
      check("rst_mid_valid", valid, 0);
      check("rst_mid_wd", csr_wd, 0);
      check("rst_mid_busy", busy, 0);
      rst_n = 1'b1;
      saw = 1'b0;
      repeat (6) begin @(negedge clk); if (valid || csr_we) saw = 1'b1; end
      check("rst_no_resume", saw, 0);
      check("rst_no_write", csr_mem[12'h305], ref_mem[12'h305]);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
